// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with a small byte FIFO.
// Deserialises 11-bit frames from the raw ps2_clk/ps2_data pins, validates
// start/parity/stop, aborts stalled frames on a timeout, and queues good
// scan-code bytes for a downstream consumer using a ready/nextdata_n handshake.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    BIT_STOP = 4'd10;

  // Pin synchronisers: [0],[1] are the two sync stages, clk_sync[2] is history.
  logic [2:0] clk_sync_q, clk_sync_d;
  logic [1:0] dat_sync_q, dat_sync_d;

  // Frame reception state.
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // FIFO state.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic          ovf_q, ovf_d;
  logic          ferr_q, ferr_d;

  logic fall;
  logic data_s;
  logic frame_done;
  logic frame_ok;
  logic timeout;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
  assign data_s = dat_sync_q[1];

  // Shift raw pins through the synchroniser chains.
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
  end

  // Bit counting, shifting, end-of-frame check and stall timeout.
  // The shift register fills from the top, so after bits 0..9 it holds
  // {parity, D7..D0, start}; the stop bit is taken straight from the pin.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    to_cnt_d   = to_cnt_q;
    frame_done = 1'b0;
    frame_ok   = 1'b0;
    timeout    = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == BIT_STOP) begin
        bit_cnt_d  = 4'd0;
        frame_done = 1'b1;
        frame_ok   = ~shreg_q[0] & data_s & (^shreg_q[9:1]);
      end else begin
        shreg_d   = {data_s, shreg_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TO_LAST) begin
        timeout   = 1'b1;
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // FIFO push/pop, overflow flag and error pulse.
  // A push into a full FIFO is allowed when a pop frees the head slot in the
  // same cycle; the head is read before the edge, so the overwrite is safe.
  always_comb begin
    pop      = ~nextdata_n & ~empty;
    push     = frame_done & frame_ok & (~full | pop);
    drop     = frame_done & frame_ok & full & ~pop;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = shreg_q[8:1];
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    ovf_d    = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (pop) begin
      ovf_d = 1'b0;
    end
    ferr_d   = (frame_done & ~frame_ok) | timeout;
  end

  // Control registers with synchronous active-low reset; sync chains idle high.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
      bit_cnt_q  <= 4'd0;
      shreg_q    <= '0;
      to_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      to_cnt_q   <= to_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
    end
  end

  // FIFO storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ready     = ~empty;
  assign data      = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule
